// File: rtl/button_bounce_gen.sv
// Turns a one-cycle press request into a bouncy press / hold / release button waveform.
// Bounce intervals come from a free-running 16-bit Galois LFSR.
module button_bounce_gen #(
    parameter int          BOUNCE_PAIRS = 3,
    parameter int          TOGGLE_W     = 8,
    parameter int          HOLD_W       = 22,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              press_req,
    input  logic [HOLD_W-1:0] hold_len,
    output logic              button_out,
    output logic              busy,
    output logic              done
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0] TAPS     = 16'hB400;
    localparam int          TL_W     = (BOUNCE_PAIRS == 0) ? 1 : $clog2(2 * BOUNCE_PAIRS + 1);
    localparam logic [TL_W-1:0] TOGGLES = TL_W'(2 * BOUNCE_PAIRS);

    typedef enum logic [1:0] {IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE} state_t;

    state_t              state, state_nxt;
    logic [15:0]         lfsr;
    logic [TOGGLE_W-1:0] tmr, tmr_nxt, interval;
    logic [TL_W-1:0]     tl, tl_nxt;
    logic [HOLD_W-1:0]   hold_lat, hold_lat_nxt, hold_cnt, hold_cnt_nxt, hold_eff;
    logic                btn_nxt, done_nxt, expire, last_toggle;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endfunction

    assign interval    = (lfsr[TOGGLE_W-1:0] == '0) ? TOGGLE_W'(1) : lfsr[TOGGLE_W-1:0];
    assign hold_eff    = (hold_len == '0) ? HOLD_W'(1) : hold_len;
    assign expire      = (tmr == TOGGLE_W'(1));
    assign last_toggle = (tl == TL_W'(1));
    assign busy        = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        btn_nxt      = button_out;
        done_nxt     = 1'b0;
        tmr_nxt      = tmr;
        tl_nxt       = tl;
        hold_lat_nxt = hold_lat;
        hold_cnt_nxt = hold_cnt;
        case (state)
            IDLE: begin
                if (press_req) begin
                    hold_lat_nxt = hold_eff;
                    hold_cnt_nxt = hold_eff;
                    btn_nxt      = 1'b1;
                    tl_nxt       = TOGGLES;
                    tmr_nxt      = interval;
                    state_nxt    = (BOUNCE_PAIRS == 0) ? HOLD : PRESS_BOUNCE;
                end
            end
            PRESS_BOUNCE: begin
                if (expire) begin
                    btn_nxt = ~button_out;
                    tl_nxt  = tl - TL_W'(1);
                    tmr_nxt = interval;
                    // Hold is counted from the final rising bounce edge.
                    if (last_toggle) begin
                        state_nxt    = HOLD;
                        hold_cnt_nxt = hold_lat;
                    end
                end else begin
                    tmr_nxt = tmr - TOGGLE_W'(1);
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_W'(1)) begin
                    btn_nxt = 1'b0;
                    tl_nxt  = TOGGLES;
                    tmr_nxt = interval;
                    if (BOUNCE_PAIRS == 0) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = RELEASE_BOUNCE;
                    end
                end else begin
                    hold_cnt_nxt = hold_cnt - HOLD_W'(1);
                end
            end
            RELEASE_BOUNCE: begin
                if (expire) begin
                    btn_nxt = ~button_out;
                    tl_nxt  = tl - TL_W'(1);
                    tmr_nxt = interval;
                    if (last_toggle) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    tmr_nxt = tmr - TOGGLE_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            button_out <= 1'b0;
            done       <= 1'b0;
            lfsr       <= SEED_EFF;
            tmr        <= '0;
            tl         <= '0;
            hold_lat   <= '0;
            hold_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            button_out <= btn_nxt;
            done       <= done_nxt;
            lfsr       <= lfsr_step(lfsr);
            tmr        <= tmr_nxt;
            tl         <= tl_nxt;
            hold_lat   <= hold_lat_nxt;
            hold_cnt   <= hold_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_button_bounce_gen.sv
// Bench for button_bounce_gen: instances with clean edges, 3 bounce pairs, and SEED=0,
// checked cycle by cycle against an edge-schedule model built from the LFSR rules.
module tb_button_bounce_gen;
    localparam int HW = 22;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          press0 = 1'b0;
    logic          press3 = 1'b0;
    logic [HW-1:0] hold_len = '0;
    logic          bo0, busy0, done0, bo3, busy3, done3, boz, busyz, donez;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [15:0]   m_lfsr;
    int            ev[0:15];
    int            n_ev;
    int            t_done;

    always #5 clk = ~clk;

    button_bounce_gen #(.BOUNCE_PAIRS(0), .TOGGLE_W(8), .HOLD_W(HW), .SEED(16'hACE1)) dut0 (
        .clk(clk), .reset(reset), .press_req(press0), .hold_len(hold_len),
        .button_out(bo0), .busy(busy0), .done(done0));
    button_bounce_gen #(.BOUNCE_PAIRS(3), .TOGGLE_W(8), .HOLD_W(HW), .SEED(16'hACE1)) dut3 (
        .clk(clk), .reset(reset), .press_req(press3), .hold_len(hold_len),
        .button_out(bo3), .busy(busy3), .done(done3));
    button_bounce_gen #(.BOUNCE_PAIRS(3), .TOGGLE_W(8), .HOLD_W(HW), .SEED(16'h0000)) dutz (
        .clk(clk), .reset(reset), .press_req(press3), .hold_len(hold_len),
        .button_out(boz), .busy(busyz), .done(donez));

    // Polynomial x^16+x^14+x^13+x^11+1 in right-shifting Galois form.
    function automatic logic [15:0] adv(input logic [15:0] v, input int n);
        logic [15:0] mask;
        mask = 16'((1 << 15) | (1 << 13) | (1 << 12) | (1 << 10));
        for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ mask) : (v >> 1);
        return v;
    endfunction

    always @(posedge clk or posedge reset)
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= adv(m_lfsr, 1);

    // Edge times relative to the acceptance edge; the final one is the done cycle.
    task automatic build(input logic [15:0] l0, input int h, input int bp);
        logic [15:0] l;
        int t, n;
        l = l0; t = 0; n_ev = 0;
        for (int i = 0; i < 2 * bp; i++) begin
            n = int'(l[7:0]); if (n == 0) n = 1;
            l = adv(l, n); t += n; ev[n_ev] = t; n_ev++;
        end
        n = (h == 0) ? 1 : h;
        l = adv(l, n); t += n; ev[n_ev] = t; n_ev++;
        for (int i = 0; i < 2 * bp; i++) begin
            n = int'(l[7:0]); if (n == 0) n = 1;
            l = adv(l, n); t += n; ev[n_ev] = t; n_ev++;
        end
        t_done = t;
    endtask

    function automatic logic lvl(input int r);
        int c = 0;
        for (int i = 0; i < n_ev; i++) if (ev[i] <= r) c++;
        return (c % 2) == 0;
    endfunction

    task automatic set_press(input int which, input logic v);
        if (which == 0) press0 = v; else press3 = v;
    endtask

    task automatic run_seq(input int which, input int h, input bit pre, input bit poke,
                           input int chain_h, input bit abort);
        int bp, rises, dones, poke_r, abort_r, last_r;
        logic prev, e_bo, e_busy, e_done, a_bo, a_busy, a_done;
        bp = (which == 0) ? 0 : 3;
        if (!pre) begin set_press(which, 1'b1); hold_len = HW'(h); end
        build(m_lfsr, h, bp);
        poke_r  = (bp == 0) ? 0 : ev[2 * bp - 1];
        abort_r = abort ? ev[2 * bp + 1] : -1;
        last_r  = (chain_h < 0) ? t_done + 1 : t_done;
        prev = 1'b0; rises = 0; dones = 0;
        for (int r = 0; r <= last_r; r++) begin
            @(negedge clk);
            set_press(which, 1'b0);
            if (r == 0) hold_len = HW'($urandom_range(0, 400));
            if (poke && r == poke_r) begin set_press(which, 1'b1); hold_len = HW'($urandom_range(1, 50)); end
            e_bo = (r <= t_done) ? lvl(r) : 1'b0;
            e_busy = (r < t_done);
            e_done = (r == t_done);
            if (which == 0) {a_bo, a_busy, a_done} = {bo0, busy0, done0};
            else            {a_bo, a_busy, a_done} = {bo3, busy3, done3};
            n_checks += 3;
            if (a_bo !== e_bo)     begin n_fail++; $display("FAIL button_out dut%0d r=%0d got %b exp %b", which, r, a_bo, e_bo); end
            if (a_busy !== e_busy) begin n_fail++; $display("FAIL busy dut%0d r=%0d got %b exp %b", which, r, a_busy, e_busy); end
            if (a_done !== e_done) begin n_fail++; $display("FAIL done dut%0d r=%0d got %b exp %b", which, r, a_done, e_done); end
            if (which != 0) begin
                n_checks += 2;
                if (boz !== e_bo)     begin n_fail++; $display("FAIL seed0 button_out r=%0d got %b exp %b", r, boz, e_bo); end
                if (donez !== e_done) begin n_fail++; $display("FAIL seed0 done r=%0d got %b exp %b", r, donez, e_done); end
            end
            if (a_bo === 1'b1 && prev !== 1'b1) rises++;
            prev = a_bo;
            if (a_done === 1'b1) dones++;
            if (r == abort_r) begin
                #1 reset = 1'b1;
                #1;
                n_checks += 4;
                if (bo3 !== 1'b0)   begin n_fail++; $display("FAIL abort button_out got %b exp 0", bo3); end
                if (busy3 !== 1'b0) begin n_fail++; $display("FAIL abort busy got %b exp 0", busy3); end
                if (boz !== 1'b0)   begin n_fail++; $display("FAIL abort seed0 button_out got %b exp 0", boz); end
                if (busyz !== 1'b0) begin n_fail++; $display("FAIL abort seed0 busy got %b exp 0", busyz); end
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    n_checks++;
                    if ((done3 | donez) !== 1'b0) begin n_fail++; $display("FAIL abort done cyc=%0d got %b exp 0", k, done3 | donez); end
                end
                reset = 1'b0;
                return;
            end
            if (r == t_done && chain_h >= 0) begin set_press(which, 1'b1); hold_len = HW'(chain_h); end
        end
        n_checks += 2;
        if (rises != 2 * bp + 1) begin n_fail++; $display("FAIL rise_count dut%0d got %0d exp %0d", which, rises, 2 * bp + 1); end
        if (dones != 1)          begin n_fail++; $display("FAIL done_count dut%0d got %0d exp 1", which, dones); end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #1;
        n_checks += 2;
        if ({bo0, busy0, done0, bo3, busy3, done3} !== 6'b0) begin
            n_fail++; $display("FAIL reset_async got %b exp 000000", {bo0, busy0, done0, bo3, busy3, done3});
        end
        if ({boz, busyz, donez} !== 3'b0) begin n_fail++; $display("FAIL reset_seed0 got %b exp 000", {boz, busyz, donez}); end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bo0, busy0, done0, bo3, busy3, done3} !== 6'b0) begin
            n_fail++; $display("FAIL reset_held got %b exp 000000", {bo0, busy0, done0, bo3, busy3, done3});
        end
        reset = 1'b0;
    endtask

    task automatic test_bounce_hold100;
        repeat (7) @(negedge clk);
        run_seq(3, 100, 1'b0, 1'b0, -1, 1'b0);
    endtask

    task automatic test_clean_edges;
        run_seq(0, 5, 1'b0, 1'b0, -1, 1'b0);
        run_seq(0, 0, 1'b0, 1'b0, -1, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_seq(3, 40, 1'b0, 1'b1, 25, 1'b0);
        run_seq(3, 25, 1'b1, 1'b0, -1, 1'b0);
        run_seq(0, 3, 1'b0, 1'b1, 4, 1'b0);
        run_seq(0, 4, 1'b1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_seq((i % 2 == 0) ? 3 : 0, $urandom_range(0, 200), 1'b0, 1'b0, -1, 1'b0);
        end
    endtask

    task automatic test_reset_abort;
        run_seq(3, 60, 1'b0, 1'b0, -1, 1'b1);
        test_bounce_hold100;
    endtask

    initial begin
        test_reset;
        test_bounce_hold100;
        test_clean_edges;
        test_back_to_back;
        test_random;
        test_reset_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
